// File: rtl/count_seq_ctrl.sv
// Command-driven sequencer for a WIDTH-bit up-counter: runs (repeat+1) wrap
// periods of (limit+1) cycles each, then posts a completion record.
module count_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [RPT_W-1:0] cmd_repeat,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             done_aborted,
  output logic [RPT_W:0]   done_periods
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic [RPT_W-1:0] remain_q;
  logic [RPT_W:0]   periods_q;
  logic             aborted_q;
  logic             at_term;

  assign at_term = (count_q == limit_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      limit_q   <= '0;
      remain_q  <= '0;
      periods_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          count_q <= '0;
          if (cmd_valid) begin
            limit_q   <= cmd_limit;
            remain_q  <= cmd_repeat;
            periods_q <= '0;
            aborted_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          // abort outranks pause, which outranks the terminal-count check
          if (abort) begin
            count_q   <= '0;
            aborted_q <= 1'b1;
            state_q   <= DONE;
          end else if (!pause) begin
            if (at_term) begin
              count_q   <= '0;
              periods_q <= periods_q + 1'b1;
              if (remain_q == '0) begin
                state_q <= DONE;
              end else begin
                remain_q <= remain_q - 1'b1;
              end
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        DONE: begin
          count_q <= '0;
          if (done_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done_valid   = (state_q == DONE);
  assign tick         = (state_q == RUN) && !pause && !abort && at_term;
  assign count        = count_q;
  assign done_aborted = aborted_q;
  assign done_periods = periods_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed scenarios plus random traffic, all checked
// against a model that tracks elapsed unpaused cycles within a run.
module tb_count_seq_ctrl;

  localparam int W  = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_limit;
  logic [RW-1:0] cmd_repeat;
  logic          pause;
  logic          abort;
  logic [W-1:0]  count;
  logic          tick;
  logic          busy;
  logic          done_valid;
  logic          done_ready;
  logic          done_aborted;
  logic [RW:0]   done_periods;

  int n_cmp  = 0;
  int n_fail = 0;

  count_seq_ctrl #(.WIDTH(W), .RPT_W(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_limit    (cmd_limit),
    .cmd_repeat   (cmd_repeat),
    .pause        (pause),
    .abort        (abort),
    .count        (count),
    .tick         (tick),
    .busy         (busy),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_aborted (done_aborted),
    .done_periods (done_periods)
  );

  always #5 clk = ~clk;

  // Model: 0=idle, 1=run, 2=done. In a run, m_act counts unpaused cycles so far;
  // counter position and completed periods follow from division by (L+1).
  int m_st  = 0;
  int m_act = 0;
  int m_L   = 0;
  int m_R   = 0;
  int m_per = 0;
  bit m_ab  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_act = 0; m_per = 0; m_ab = 1'b0; m_L = 0; m_R = 0;
    end else begin
      case (m_st)
        0: if (cmd_valid) begin
          m_st = 1; m_act = 0; m_L = int'(cmd_limit); m_R = int'(cmd_repeat);
          m_per = 0; m_ab = 1'b0;
        end
        1: begin
          if (abort) begin
            m_st = 2; m_ab = 1'b1; m_per = m_act / (m_L + 1);
          end else if (!pause) begin
            m_act++;
            if (m_act == (m_R + 1) * (m_L + 1)) begin
              m_st = 2; m_per = m_R + 1;
            end
          end
        end
        default: if (done_ready) m_st = 0;
      endcase
    end
  end

  logic [13:0] obs;
  logic [13:0] exp_v;

  assign obs = {cmd_ready, busy, done_valid, tick, count, done_aborted, done_periods};

  always_comb begin
    int plen;
    int pos;
    plen = m_L + 1;
    pos  = m_act % plen;
    case (m_st)
      0:       exp_v = {4'b1000, 4'd0, m_ab, 5'(m_per)};
      1:       exp_v = {3'b010, (!pause && !abort && pos == m_L), 4'(pos), 1'b0, 5'(m_act / plen)};
      default: exp_v = {4'b0110, 4'd0, m_ab, 5'(m_per)};
    endcase
  end

  task automatic idle_inputs();
    rst = 1'b0; cmd_valid = 1'b0; cmd_limit = '0; cmd_repeat = '0;
    pause = 1'b0; abort = 1'b0; done_ready = 1'b1;
  endtask

  task automatic test_reset();
    cmd_limit = 4'd5; cmd_repeat = 4'd0;
    for (int i = 0; i < 10; i++) begin
      rst       = (i < 2) || (i >= 6 && i <= 8);
      cmd_valid = (i == 2);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL reset_model c%0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 6) begin
        n_cmp++;
        if (count !== 4'd3) begin
          n_fail++; $display("FAIL reset_midrun_count: got %0d expected 3", count);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if ({count, busy, cmd_ready, done_valid, tick} !== {4'd0, 4'b0100}) begin
          n_fail++;
          $display("FAIL reset_state: got cnt=%0d busy=%b rdy=%b dv=%b tick=%b expected 0/0/1/0/0",
                   count, busy, cmd_ready, done_valid, tick);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_single();
    for (int i = 0; i < 8; i++) begin
      cmd_valid = (i == 0); cmd_limit = 4'd3; cmd_repeat = 4'd0;
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL single_model c%0d: got %h expected %h", i, obs, exp_v);
      end
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if (count !== 4'(i - 1) || tick !== (i == 4)) begin
          n_fail++;
          $display("FAIL single_seq c%0d: got cnt=%0d tick=%b expected cnt=%0d tick=%b",
                   i, count, tick, i - 1, i == 4);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if ({done_valid, done_aborted, done_periods} !== {2'b10, 5'd1}) begin
          n_fail++; $display("FAIL single_done: got dv=%b ab=%b per=%0d expected 1/0/1",
                             done_valid, done_aborted, done_periods);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
          n_fail++; $display("FAIL single_idle: got rdy=%b busy=%b expected 1/0", cmd_ready, busy);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_repeat_wrap();
    for (int i = 0; i < 12; i++) begin
      cmd_valid = (i == 0); cmd_limit = 4'd2; cmd_repeat = 4'd2;
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL wrap_model c%0d: got %h expected %h", i, obs, exp_v);
      end
      if (i >= 1 && i <= 9) begin
        n_cmp++;
        if (count !== 4'((i - 1) % 3) || tick !== (i % 3 == 0)) begin
          n_fail++;
          $display("FAIL wrap_seq c%0d: got cnt=%0d tick=%b expected cnt=%0d tick=%b",
                   i, count, tick, (i - 1) % 3, i % 3 == 0);
        end
      end
      if (i == 10) begin
        n_cmp++;
        if (done_valid !== 1'b1 || done_periods !== 5'd3) begin
          n_fail++; $display("FAIL wrap_done: got dv=%b per=%0d expected 1/3", done_valid, done_periods);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_pause();
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i == 0); cmd_limit = 4'd4; cmd_repeat = 4'd0;
      pause = (i == 3 || i == 4);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL pause_model c%0d: got %h expected %h", i, obs, exp_v);
      end
      if (i >= 3 && i <= 5) begin
        n_cmp++;
        if (count !== 4'd2) begin
          n_fail++; $display("FAIL pause_hold c%0d: got %0d expected 2", i, count);
        end
      end
      if (i == 5 || i == 7) begin
        n_cmp++;
        if (tick !== (i == 7)) begin
          n_fail++; $display("FAIL pause_tick c%0d: got %b expected %b", i, tick, i == 7);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (done_valid !== 1'b1 || done_periods !== 5'd1) begin
          n_fail++; $display("FAIL pause_done: got dv=%b per=%0d expected 1/1", done_valid, done_periods);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    for (int i = 0; i < 11; i++) begin
      cmd_valid = (i == 0); cmd_limit = 4'd3; cmd_repeat = 4'd1;
      abort = (i == 8); pause = (i == 8);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL abort_model c%0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 8) begin
        n_cmp++;
        if (count !== 4'd3 || tick !== 1'b0) begin
          n_fail++; $display("FAIL abort_tick: got cnt=%0d tick=%b expected 3/0", count, tick);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if ({done_valid, done_aborted, done_periods} !== {2'b11, 5'd1}) begin
          n_fail++; $display("FAIL abort_done: got dv=%b ab=%b per=%0d expected 1/1/1",
                             done_valid, done_aborted, done_periods);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  // Second command (limit=0, repeat=3) is held pending through the DONE stall.
  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++) begin
      cmd_valid  = 1'b1;
      cmd_limit  = (i == 0) ? 4'd1 : 4'd0;
      cmd_repeat = (i == 0) ? 4'd0 : 4'd3;
      done_ready = (i >= 8);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL b2b_model c%0d: got %h expected %h", i, obs, exp_v);
      end
      if (i >= 3 && i <= 8) begin
        n_cmp++;
        if ({done_valid, cmd_ready, done_aborted, done_periods} !== {3'b100, 5'd1}) begin
          n_fail++; $display("FAIL b2b_stall c%0d: got dv=%b rdy=%b ab=%b per=%0d expected 1/0/0/1",
                             i, done_valid, cmd_ready, done_aborted, done_periods);
        end
      end
      if (i == 9 || i == 10) begin
        n_cmp++;
        if (cmd_ready !== (i == 9) || busy !== (i == 10)) begin
          n_fail++; $display("FAIL b2b_accept c%0d: got rdy=%b busy=%b", i, cmd_ready, busy);
        end
      end
      if (i >= 10 && i <= 13) begin
        n_cmp++;
        if (tick !== 1'b1 || count !== 4'd0) begin
          n_fail++; $display("FAIL limit0_tick c%0d: got tick=%b cnt=%0d expected 1/0", i, tick, count);
        end
      end
      if (i == 14) begin
        n_cmp++;
        if (done_valid !== 1'b1 || done_periods !== 5'd4 || tick !== 1'b0) begin
          n_fail++; $display("FAIL limit0_done: got dv=%b per=%0d tick=%b expected 1/4/0",
                             done_valid, done_periods, tick);
        end
      end
      if (i == 14) cmd_valid = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      cmd_valid  = ($urandom_range(0, 1) == 1);
      cmd_limit  = 4'($urandom_range(0, 5));
      cmd_repeat = 4'($urandom_range(0, 3));
      pause      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      done_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random_model c%0d: got %h expected %h", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single();
    test_repeat_wrap();
    test_pause();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
